// File: rtl/mp_ram.sv
// Multi-port RAM with per-byte write enables, selectable read latency,
// optional write-first bypass and a zeroing sweep after reset.
module mp_ram #(
    parameter int OPTN_DATA_WIDTH   = 32,
    parameter int OPTN_RAM_DEPTH    = 32,
    parameter int OPTN_NUM_RD_PORTS = 2,
    parameter int OPTN_NUM_WR_PORTS = 2,
    parameter int OPTN_RD_LATENCY   = 0,
    parameter int OPTN_WR_BYPASS    = 1,
    localparam int RAM_IDX_WIDTH    = $clog2(OPTN_RAM_DEPTH),
    localparam int NUM_BYTES        = OPTN_DATA_WIDTH / 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    output logic                                           o_ram_ready,
    input  logic [OPTN_NUM_RD_PORTS-1:0]                   i_ram_rd_en,
    input  logic [OPTN_NUM_RD_PORTS-1:0][RAM_IDX_WIDTH-1:0] i_ram_rd_addr,
    output logic [OPTN_NUM_RD_PORTS-1:0][OPTN_DATA_WIDTH-1:0] o_ram_rd_data,
    input  logic [OPTN_NUM_WR_PORTS-1:0]                   i_ram_wr_en,
    input  logic [OPTN_NUM_WR_PORTS-1:0][RAM_IDX_WIDTH-1:0] i_ram_wr_addr,
    input  logic [OPTN_NUM_WR_PORTS-1:0][NUM_BYTES-1:0]    i_ram_wr_byte_en,
    input  logic [OPTN_NUM_WR_PORTS-1:0][OPTN_DATA_WIDTH-1:0] i_ram_wr_data
);

    localparam logic [RAM_IDX_WIDTH:0] DEPTH_L =
        (RAM_IDX_WIDTH+1)'(OPTN_RAM_DEPTH);
    localparam logic [RAM_IDX_WIDTH-1:0] LAST_IDX =
        RAM_IDX_WIDTH'(OPTN_RAM_DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t                   state_q, state_d;
    logic [RAM_IDX_WIDTH-1:0] init_idx_q, init_idx_d;
    logic                     ready;
    logic [OPTN_DATA_WIDTH-1:0] mem [OPTN_RAM_DEPTH];
    logic [OPTN_NUM_RD_PORTS-1:0][OPTN_DATA_WIDTH-1:0] rd_next;

    function automatic logic in_range(input logic [RAM_IDX_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    // Sweep state and index; reset restarts the zeroing sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Advance the sweep one entry per cycle until the last entry is cleared
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        ready      = 1'b0;
        unique case (state_q)
            S_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == LAST_IDX)
                    state_d = S_READY;
            end
            S_READY: ready = 1'b1;
        endcase
    end

    assign o_ram_ready = ready;

    // Array update: sweep zeroes during INIT, later ports override per byte
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem[init_idx_q] <= '0;
        end else begin
            for (int p = 0; p < OPTN_NUM_WR_PORTS; p++) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (i_ram_wr_en[p] && i_ram_wr_byte_en[p][b] &&
                        in_range(i_ram_wr_addr[p]))
                        mem[i_ram_wr_addr[p]][8*b +: 8] <=
                            i_ram_wr_data[p][8*b +: 8];
                end
            end
        end
    end

    // Read value per port, with same-cycle write bytes merged when write-first
    always_comb begin
        rd_next = '0;
        for (int r = 0; r < OPTN_NUM_RD_PORTS; r++) begin
            if (ready && i_ram_rd_en[r] && in_range(i_ram_rd_addr[r])) begin
                rd_next[r] = mem[i_ram_rd_addr[r]];
                if (OPTN_RD_LATENCY == 1 && OPTN_WR_BYPASS != 0) begin
                    for (int p = 0; p < OPTN_NUM_WR_PORTS; p++) begin
                        for (int b = 0; b < NUM_BYTES; b++) begin
                            if (i_ram_wr_en[p] && i_ram_wr_byte_en[p][b] &&
                                i_ram_wr_addr[p] == i_ram_rd_addr[r])
                                rd_next[r][8*b +: 8] =
                                    i_ram_wr_data[p][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    if (OPTN_RD_LATENCY == 0) begin : g_lat0
        assign o_ram_rd_data = rd_next;
    end else begin : g_lat1
        logic [OPTN_NUM_RD_PORTS-1:0][OPTN_DATA_WIDTH-1:0] rd_q;

        // Output registers hold the value sampled at the read edge
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                rd_q <= '0;
            else
                rd_q <= rd_next;
        end

        assign o_ram_rd_data = rd_q;
    end

endmodule
